// File: rtl/mor1kx_wb_arbiter_marocchino_pkg.sv
// Shared write-back source indices and grant helpers for the MAROCCHINO write-back arbiter.
package mor1kx_wb_arbiter_marocchino_pkg;

  localparam int unsigned WB_NUM_SRC   = 4;
  localparam int unsigned WB_SRC_IDX_W = 2;

  localparam int unsigned WB_SRC_LSU = 0;
  localparam int unsigned WB_SRC_DIV = 1;
  localparam int unsigned WB_SRC_MUL = 2;
  localparam int unsigned WB_SRC_ALU = 3;

  // Isolate the lowest set request bit: lowest index has highest priority.
  function automatic logic [WB_NUM_SRC-1:0] wb_fixed_prio(input logic [WB_NUM_SRC-1:0] req);
    return req & (~req + WB_NUM_SRC'(1));
  endfunction

  function automatic logic [WB_SRC_IDX_W-1:0] wb_onehot_idx(input logic [WB_NUM_SRC-1:0] oh);
    logic [WB_SRC_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < WB_NUM_SRC; i++) begin
      if (oh[i]) idx = WB_SRC_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mor1kx_wb_aging_cnt_marocchino.sv
// Saturating starvation counter for one write-back source; sat_c flags that the
// source has waited AGING_LIMIT advances without being granted.
module mor1kx_wb_aging_cnt_marocchino #(
  parameter int unsigned AGING_LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_i,
  input  logic padv_i,
  input  logic flush_i,
  input  logic grant_i,
  output logic sat_c
);

  localparam int unsigned CNT_W = $clog2(AGING_LIMIT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A granted advance is an ack, so it clears the counter like a drop of valid.
  always_comb begin
    cnt_d = cnt_q;
    if (flush_i || !valid_i) begin
      cnt_d = '0;
    end else if (padv_i) begin
      if (grant_i) begin
        cnt_d = '0;
      end else if (cnt_q != CNT_W'(AGING_LIMIT)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign sat_c = (cnt_q == CNT_W'(AGING_LIMIT));

endmodule

// File: rtl/mor1kx_wb_arbiter_marocchino.sv
// MAROCCHINO write-back arbiter: grants one of LSU/DIV/MUL/ALU per advance and
// registers the write-back triple. Define MOR1KX_WB_ARB_AGING_EN for starvation aging.
module mor1kx_wb_arbiter_marocchino
  import mor1kx_wb_arbiter_marocchino_pkg::*;
#(
  parameter int unsigned OPTION_OPERAND_WIDTH = 32,
  parameter int unsigned OPTION_RF_ADDR_WIDTH = 5,
  parameter int unsigned AGING_LIMIT          = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              padv_wb_i,
  input  logic                              pipeline_flush_i,
  input  logic [3:0]                        src_valid_i,
  input  logic [3:0]                        src_rf_wb_i,
  input  logic [4*OPTION_RF_ADDR_WIDTH-1:0] src_rfd_adr_i,
  input  logic [4*OPTION_OPERAND_WIDTH-1:0] src_result_i,
  output logic [3:0]                        src_ack_o,
  output logic                              wb_new_result_o,
  output logic                              wb_rf_wb_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0]   wb_rfd_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   wb_result_o,
  output logic [1:0]                        wb_src_o
);

  localparam int unsigned AW = OPTION_RF_ADDR_WIDTH;
  localparam int unsigned DW = OPTION_OPERAND_WIDTH;

  logic [WB_NUM_SRC-1:0]   grant_c;
  logic [WB_SRC_IDX_W-1:0] sel_idx_c;
  logic                    adv_c;

`ifdef MOR1KX_WB_ARB_AGING_EN
  logic [WB_NUM_SRC-1:0] sat_c;
  logic [WB_NUM_SRC-1:0] aged_c;

  assign sat_c[WB_SRC_LSU] = 1'b0;

  for (genvar s = 1; s < WB_NUM_SRC; s++) begin : g_age
    mor1kx_wb_aging_cnt_marocchino #(
      .AGING_LIMIT (AGING_LIMIT)
    ) u_age (
      .clk     (clk),
      .rst     (rst),
      .valid_i (src_valid_i[s]),
      .padv_i  (padv_wb_i),
      .flush_i (pipeline_flush_i),
      .grant_i (grant_c[s]),
      .sat_c   (sat_c[s])
    );
  end

  // A counter still reads saturated in the cycle its source drops valid; mask it.
  assign aged_c  = sat_c & src_valid_i;
  assign grant_c = (|aged_c) ? wb_fixed_prio(aged_c) : wb_fixed_prio(src_valid_i);
`else
  logic aging_limit_unused;
  assign aging_limit_unused = (AGING_LIMIT == 0);
  assign grant_c = wb_fixed_prio(src_valid_i);
`endif

  // Reset acts as a flush for the acknowledge path.
  assign adv_c     = padv_wb_i & ~pipeline_flush_i & ~rst;
  assign src_ack_o = grant_c & {WB_NUM_SRC{adv_c}};
  assign sel_idx_c = wb_onehot_idx(grant_c);

  logic          new_result_q, new_result_d;
  logic          rf_wb_q,      rf_wb_d;
  logic [AW-1:0] rfd_adr_q,    rfd_adr_d;
  logic [DW-1:0] result_q,     result_d;
  logic [1:0]    src_q,        src_d;

  always_comb begin
    new_result_d = 1'b0;
    rf_wb_d      = rf_wb_q;
    rfd_adr_d    = rfd_adr_q;
    result_d     = result_q;
    src_d        = src_q;
    if (pipeline_flush_i) begin
      rf_wb_d = 1'b0;
    end else if (padv_wb_i) begin
      if (|grant_c) begin
        new_result_d = 1'b1;
        rf_wb_d      = src_rf_wb_i[sel_idx_c];
        rfd_adr_d    = src_rfd_adr_i[sel_idx_c*AW +: AW];
        result_d     = src_result_i[sel_idx_c*DW +: DW];
        src_d        = sel_idx_c;
      end else begin
        // Empty advance: bubble into WB, keep the last address/result visible.
        rf_wb_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      new_result_q <= 1'b0;
      rf_wb_q      <= 1'b0;
      rfd_adr_q    <= '0;
      result_q     <= '0;
      src_q        <= '0;
    end else begin
      new_result_q <= new_result_d;
      rf_wb_q      <= rf_wb_d;
      rfd_adr_q    <= rfd_adr_d;
      result_q     <= result_d;
      src_q        <= src_d;
    end
  end

  assign wb_new_result_o = new_result_q;
  assign wb_rf_wb_o      = rf_wb_q;
  assign wb_rfd_adr_o    = rfd_adr_q;
  assign wb_result_o     = result_q;
  assign wb_src_o        = src_q;

endmodule

// File: tb/tb_mor1kx_wb_arbiter_marocchino.sv
// Self-checking bench for mor1kx_wb_arbiter_marocchino against a behavioural model
// (aging expectations follow MOR1KX_WB_ARB_AGING_EN).
module tb_mor1kx_wb_arbiter_marocchino;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned LIMIT = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           padv;
  logic           flush;
  logic [3:0]     valid;
  logic [3:0]     rfw;
  logic [4*AW-1:0] adr;
  logic [4*DW-1:0] res;
  logic [3:0]     ack;
  logic           new_res;
  logic           wb_rf_wb;
  logic [AW-1:0]  wb_adr;
  logic [DW-1:0]  wb_res;
  logic [1:0]     wb_src;

  mor1kx_wb_arbiter_marocchino #(
    .OPTION_OPERAND_WIDTH (DW),
    .OPTION_RF_ADDR_WIDTH (AW),
    .AGING_LIMIT          (LIMIT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .padv_wb_i        (padv),
    .pipeline_flush_i (flush),
    .src_valid_i      (valid),
    .src_rf_wb_i      (rfw),
    .src_rfd_adr_i    (adr),
    .src_result_i     (res),
    .src_ack_o        (ack),
    .wb_new_result_o  (new_res),
    .wb_rf_wb_o       (wb_rf_wb),
    .wb_rfd_adr_o     (wb_adr),
    .wb_result_o      (wb_res),
    .wb_src_o         (wb_src)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model of the architectural WB state
  logic          m_new, m_rf_wb;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_res;
  logic [1:0]    m_src;
  int            m_wait [4];
  logic [3:0]    exp_ack, obs_ack;

  function automatic int pick(input logic [3:0] v);
    int g;
    g = -1;
`ifdef MOR1KX_WB_ARB_AGING_EN
    for (int s = 1; s < 4; s++)
      if (g < 0 && v[s] && m_wait[s] == int'(LIMIT)) g = s;
`endif
    for (int s = 0; s < 4; s++)
      if (g < 0 && v[s]) g = s;
    return g;
  endfunction

  // Drive one cycle, capture the ack before the edge, advance the model.
  task automatic do_cycle(input logic r, input logic p, input logic f);
    int  g;
    logic go;
    rst = r; padv = p; flush = f;
    #1;
    obs_ack = ack;
    g  = pick(valid);
    go = p && !f && !r;
    exp_ack = (g >= 0 && go) ? (4'(1) << g) : 4'b0;
    for (int s = 1; s < 4; s++) begin
      if (r || f || !valid[s])      m_wait[s] = 0;
      else if (p && g == s)         m_wait[s] = 0;
      else if (p && m_wait[s] < int'(LIMIT)) m_wait[s]++;
    end
    if (r) begin
      m_new = 0; m_rf_wb = 0; m_adr = '0; m_res = '0; m_src = '0;
    end else if (f) begin
      m_new = 0; m_rf_wb = 0;
    end else if (p && g >= 0) begin
      m_new = 1; m_rf_wb = rfw[g]; m_adr = adr[g*AW +: AW];
      m_res = res[g*DW +: DW]; m_src = 2'(g);
    end else begin
      m_new = 0;
      if (p) m_rf_wb = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    valid[s] = v; rfw[s] = w; adr[s*AW +: AW] = a; res[s*DW +: DW] = d;
  endtask

  task automatic test_reset();
    valid = 4'hF; rfw = 4'hF; adr = '1; res = '1;
    do_cycle(1'b1, 1'b1, 1'b0);
    vectors++;
    if (obs_ack !== 4'b0) begin
      miscompares++; $display("FAIL reset_ack: got %b want 0000", obs_ack);
    end
    vectors++;
    if ({new_res, wb_rf_wb, wb_adr, wb_res, wb_src} !== '0) begin
      miscompares++;
      $display("FAIL reset_outs: got new=%b rf=%b adr=%h res=%h src=%0d want all 0",
               new_res, wb_rf_wb, wb_adr, wb_res, wb_src);
    end
    valid = '0; rfw = '0; adr = '0; res = '0;
    do_cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_alu_single();
    set_src(3, 1'b1, 1'b1, 5'd3, 32'hDEADBEEF);
    do_cycle(1'b0, 1'b1, 1'b0);
    vectors++;
    if (obs_ack !== 4'b1000) begin
      miscompares++; $display("FAIL alu_ack: got %b want 1000", obs_ack);
    end
    valid = '0;
    vectors++;
    if ({new_res, wb_rf_wb, wb_adr, wb_res, wb_src} !== {1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 2'd3}) begin
      miscompares++;
      $display("FAIL alu_wb: got new=%b rf=%b adr=%0d res=%h src=%0d want 1 1 3 deadbeef 3",
               new_res, wb_rf_wb, wb_adr, wb_res, wb_src);
    end
  endtask

  task automatic test_back_to_back();
    set_src(0, 1'b1, 1'b1, 5'd7, 32'h1111_0000);
    set_src(2, 1'b1, 1'b1, 5'd9, 32'h2222_0000);
    do_cycle(1'b0, 1'b1, 1'b0);
    vectors++;
    if (obs_ack !== 4'b0001) begin
      miscompares++; $display("FAIL b2b_ack0: got %b want 0001", obs_ack);
    end
    valid[0] = 1'b0;
    vectors++;
    if (new_res !== 1'b1 || wb_src !== 2'd0 || wb_res !== 32'h1111_0000) begin
      miscompares++; $display("FAIL b2b_wb0: got new=%b src=%0d res=%h want 1 0 11110000", new_res, wb_src, wb_res);
    end
    do_cycle(1'b0, 1'b1, 1'b0);
    vectors++;
    if (obs_ack !== 4'b0100) begin
      miscompares++; $display("FAIL b2b_ack1: got %b want 0100", obs_ack);
    end
    valid[2] = 1'b0;
    vectors++;
    if (new_res !== 1'b1 || wb_src !== 2'd2 || wb_adr !== 5'd9) begin
      miscompares++; $display("FAIL b2b_wb1: got new=%b src=%0d adr=%0d want 1 2 9", new_res, wb_src, wb_adr);
    end
    do_cycle(1'b0, 1'b0, 1'b0);
    vectors++;
    if (new_res !== 1'b0) begin
      miscompares++; $display("FAIL b2b_single_strobe: got new=%b want 0", new_res);
    end
  endtask

  task automatic test_flush();
    set_src(0, 1'b1, 1'b1, 5'd12, 32'hCAFE_F00D);
    do_cycle(1'b0, 1'b1, 1'b1);
    vectors++;
    if (obs_ack !== 4'b0) begin
      miscompares++; $display("FAIL flush_ack: got %b want 0000", obs_ack);
    end
    vectors++;
    if (wb_rf_wb !== 1'b0 || new_res !== 1'b0) begin
      miscompares++; $display("FAIL flush_wb: got rf=%b new=%b want 0 0", wb_rf_wb, new_res);
    end
    do_cycle(1'b0, 1'b1, 1'b0);
    vectors++;
    if (obs_ack !== 4'b0001) begin
      miscompares++; $display("FAIL flush_retry_ack: got %b want 0001", obs_ack);
    end
    valid = '0;
    vectors++;
    if (new_res !== 1'b1 || wb_res !== 32'hCAFE_F00D || wb_rf_wb !== 1'b1) begin
      miscompares++; $display("FAIL flush_retry_wb: got new=%b rf=%b res=%h want 1 1 cafef00d", new_res, wb_rf_wb, wb_res);
    end
  endtask

  task automatic test_idle_advance();
    do_cycle(1'b0, 1'b1, 1'b0);
    vectors++;
    if (wb_rf_wb !== 1'b0 || new_res !== 1'b0 || wb_res !== 32'hCAFE_F00D
        || wb_adr !== 5'd12 || wb_src !== 2'd0) begin
      miscompares++;
      $display("FAIL idle_adv: got rf=%b new=%b res=%h adr=%0d src=%0d want 0 0 cafef00d 12 0",
               wb_rf_wb, new_res, wb_res, wb_adr, wb_src);
    end
  endtask

  task automatic test_starvation();
    int acked_at;
    int want_at;
    acked_at = 0;
`ifdef MOR1KX_WB_ARB_AGING_EN
    want_at = int'(LIMIT) + 1;
`else
    want_at = 0;
`endif
    set_src(3, 1'b1, 1'b1, 5'd30, 32'hA11A_A11A);
    for (int n = 1; n <= 14; n++) begin
      set_src(0, 1'b1, 1'b1, 5'(n), $urandom);
      do_cycle(1'b0, 1'b1, 1'b0);
      vectors++;
      if (obs_ack !== exp_ack) begin
        miscompares++; $display("FAIL starve_ack[%0d]: got %b want %b", n, obs_ack, exp_ack);
      end
      if (obs_ack[3] && acked_at == 0) begin
        acked_at = n;
        valid[3] = 1'b0;
      end
    end
    vectors++;
    if (acked_at != want_at) begin
      miscompares++; $display("FAIL starve_alu_ack_advance: got %0d want %0d", acked_at, want_at);
    end
    valid = '0;
    do_cycle(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int s = 0; s < 4; s++)
        if (!valid[s] && $urandom_range(2) == 0)
          set_src(s, 1'b1, 1'($urandom), 5'($urandom), $urandom);
      do_cycle(($urandom_range(63) == 0), ($urandom_range(3) != 0), ($urandom_range(15) == 0));
      vectors++;
      if (obs_ack !== exp_ack) begin
        miscompares++; $display("FAIL rand_ack[%0d]: got %b want %b", n, obs_ack, exp_ack);
      end
      vectors++;
      if ({new_res, wb_rf_wb, wb_adr, wb_res, wb_src} !== {m_new, m_rf_wb, m_adr, m_res, m_src}) begin
        miscompares++;
        $display("FAIL rand_wb[%0d]: got new=%b rf=%b adr=%0d res=%h src=%0d want %b %b %0d %h %0d",
                 n, new_res, wb_rf_wb, wb_adr, wb_res, wb_src, m_new, m_rf_wb, m_adr, m_res, m_src);
      end
      valid = valid & ~obs_ack;
    end
  endtask

  initial begin
    rst = 1'b1; padv = 1'b0; flush = 1'b0;
    valid = '0; rfw = '0; adr = '0; res = '0;
    for (int s = 0; s < 4; s++) m_wait[s] = 0;
    m_new = 0; m_rf_wb = 0; m_adr = '0; m_res = '0; m_src = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_alu_single();
    test_back_to_back();
    test_flush();
    test_idle_advance();
    test_starvation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mor1kx_wb_arbiter_marocchino.md
# mor1kx_wb_arbiter_marocchino

Write-back arbiter for the MAROCCHINO pipeline. It sits directly upstream of the MAROCCHINO register file. It collects completed results from four execution sources (LSU, DIV, MUL, 1-clock ALU) and grants one of them per write-back advance. It registers the granted result and produces the write-back triple (rf_wb, rfd address, result) plus the 1-clock new-result strobe that the register file consumes for GPR write and hazard bypass.

## Interface
Parameters:
- OPTION_OPERAND_WIDTH, 32, result width
- OPTION_RF_ADDR_WIDTH, 5, GPR address width
- AGING_LIMIT, 8, starvation threshold in cycles (1..255); used only with aging compiled in

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- padv_wb_i  in  1  write-back advance from CTRL
- pipeline_flush_i  in  1  flush; discards in-flight write-back
- src_valid_i  in  4  source has a completed result; held until acked (bit 0 LSU, 1 DIV, 2 MUL, 3 ALU)
- src_rf_wb_i  in  4  source result targets a GPR
- src_rfd_adr_i  in  4*OPTION_RF_ADDR_WIDTH  destination address per source, source n in slice n
- src_result_i  in  4*OPTION_OPERAND_WIDTH  result per source, slice n
- src_ack_o  out  4  one-hot; result consumed this cycle
- wb_new_result_o  out  1  1-clock strobe, cycle after a grant
- wb_rf_wb_o  out  1  registered GPR-write flag
- wb_rfd_adr_o  out  OPTION_RF_ADDR_WIDTH  registered destination address
- wb_result_o  out  OPTION_OPERAND_WIDTH  registered result
- wb_src_o  out  2  index of the source that produced the current WB contents

## Operation
- Grant: combinational, one-hot, over src_valid_i. The lowest index wins (LSU > DIV > MUL > ALU), unless aging overrides.
- src_ack_o = grant & {4{padv_wb_i & ~pipeline_flush_i}}. Acknowledge is issued in the same cycle as the advance.
- On an acked advance, the WB registers latch the granted source's rf_wb, rfd address, result and index.
- padv_wb_i with no valid source:
  - wb_rf_wb_o is cleared to 0 next cycle.
  - wb_new_result_o stays 0.
  - Address, result and wb_src_o hold their values.
- No advance: all WB registers hold their values, and wb_new_result_o is 0.
- Flush has priority over advance:
  - No ack is issued.
  - Next cycle, wb_rf_wb_o = 0 and wb_new_result_o = 0.
  - Aging counters are cleared.
- Reset values: all outputs are 0, including wb_src_o = 0 and address/result = 0. Aging counters are 0.
- Sources must keep valid, address and result stable until acked. The arbiter does not buffer them.
- A source that drops valid without an ack has its aging counter cleared.

## Timing
- Latency: advance plus grant in cycle N → wb_new_result_o = 1 and WB outputs updated in cycle N+1.
- Back-to-back advances give a strobe on every cycle. Each strobe is a single cycle, never stretched.
- Only one ack is issued per cycle. Sources that are valid but not granted wait with no penalty beyond aging.
- Reset asserted mid-operation behaves like a flush, plus all registers are zeroed on the next edge.

## Configuration
- Macro: MOR1KX_WB_ARB_AGING_EN.
- With the macro defined:
  - Sources 1..3 each have a saturating counter of width clog2(AGING_LIMIT+1).
  - The counter increments in each cycle where the source is valid, padv_wb_i=1, flush=0, and the source is not granted. It saturates at AGING_LIMIT.
  - The counter clears on the source's ack, on flush, or when the source is not valid.
  - If any counter equals AGING_LIMIT, the lowest-indexed saturated source gets the grant, overriding fixed priority.
- Without the macro: strict fixed priority, no counters, no extra flops.

## Structure
- The shared package/defines include holds:
  - source index constants: WB_SRC_LSU=0, WB_SRC_DIV=1, WB_SRC_MUL=2, WB_SRC_ALU=3
  - WB_NUM_SRC=4
- One sub-module: mor1kx_wb_aging_cnt_marocchino, a single saturating starvation counter instantiated three times under the macro.
- Grant logic and WB registers live in the top module.

## Test plan
- Reset, then src_valid_i=4'b1000, ALU rfd=5'd3, result=32'hDEADBEEF, padv_wb_i=1 → same cycle src_ack_o=4'b1000; next cycle wb_new_result_o=1, wb_rf_wb_o=1, wb_rfd_adr_o=3, wb_result_o=DEADBEEF, wb_src_o=3.
- src_valid_i=4'b0101 with continuous padv → LSU acked in cycle N, MUL acked in N+1; two consecutive strobes.
- Flush in the same cycle as padv with src_valid_i=4'b0001 → src_ack_o=0; next cycle wb_rf_wb_o=0 and wb_new_result_o=0; the LSU is acked on the first padv after the flush.
- padv_wb_i=1 with src_valid_i=0 after a valid write-back → wb_rf_wb_o drops to 0, wb_result_o unchanged, no strobe.
- Aging enabled, AGING_LIMIT=8: LSU valid continuously, ALU valid, padv every cycle → ALU acked on the 9th advance; counter returns to 0.
- Aging disabled, same stimulus → ALU never acked while the LSU stays valid.
